key_scan: RTL and testbench

Scanner for a 4x4 active-low matrix keypad. It is the input-side counterpart of the team's segment display drivers. It drives one keypad column low at a time and samples the row lines. Each full scan frame is debounced, and a single valid key press is reported as a one-cycle `key_vld` pulse with a 4-bit key code for downstream display and counter logic.

---
 rtl/key_scan_if.sv | 10 +
 rtl/key_scan.sv | 106 ++++++++++
 tb/tb_key_scan.sv | 138 +++++++++++++
 3 files changed

// File: rtl/key_scan_if.sv
// key_scan_if: keypad matrix lines plus the decoded key event outputs
interface key_scan_if;
   logic [3:0] key_col;
   logic [3:0] key_row;
   logic       key_vld;
   logic [3:0] key_num;
   logic       key_down;
   modport master (output key_col, key_vld, key_num, key_down, input key_row);
   modport slave (input key_col, key_vld, key_num, key_down, output key_row);
endinterface

// File: rtl/key_scan.sv
// key_scan: 4x4 active-low keypad scanner with frame debounce and single-key press events
module key_scan #(
   parameter int SCAN_CYC   = 50_000,
   parameter int DEBOUNCE_N = 20
) (
   input logic        clk,
   input logic        rst,
   key_scan_if.master bus
);
   localparam int CW = $clog2(SCAN_CYC);
   localparam int SW = $clog2(DEBOUNCE_N + 1);
   localparam logic [CW-1:0] LAST = CW'(SCAN_CYC - 1);
   localparam logic [SW-1:0] DN = SW'(DEBOUNCE_N);
   typedef enum logic [1:0] {IDLE, PRESS, MULTI} state_t;
   logic [3:0]    row_meta, row_sync;
   logic [CW-1:0] cnt0;
   logic [1:0]    cnt1;
   logic [15:0]   snap, snap_nxt, prev_snap, deb;
   logic [SW-1:0] stab_cnt, stab_nxt;
   logic          slot_end, frame_end, one_hot, vld, vld_nxt;
   logic [3:0]    idx, num, num_nxt;
   state_t        state, state_nxt;
   assign slot_end = cnt0 == LAST;
   assign frame_end = slot_end && cnt1 == 2'd3;
   assign bus.key_col = ~(4'b0001 << cnt1);
   assign bus.key_vld = vld;
   assign bus.key_num = num;
   assign bus.key_down = state == PRESS;
   assign stab_nxt = snap_nxt != prev_snap ? SW'(1) : (stab_cnt == DN ? DN : stab_cnt + 1'b1);
   // two-flop synchronizer for the asynchronous row lines; idle rows read high
   always_ff @(posedge clk) begin
      if (rst) begin
         row_meta <= '1;
         row_sync <= '1;
      end else begin
         row_meta <= bus.key_row;
         row_sync <= row_meta;
      end
   end
   // slot timer and column index, wrapping back-to-back with no idle gap
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0 <= '0;
         cnt1 <= '0;
      end else begin
         cnt0 <= slot_end ? '0 : cnt0 + 1'b1;
         cnt1 <= slot_end ? cnt1 + 1'b1 : cnt1;
      end
   end
   // merge the end-of-slot sample into the snapshot so the frame compare sees column 3 fresh
   always_comb begin
      snap_nxt = snap;
      for (int r = 0; r < 4; r++)
         if (slot_end) snap_nxt[r*4 + int'(cnt1)] = ~row_sync[r];
   end
   // frame-level debounce: count identical frames and accept once the run is long enough
   always_ff @(posedge clk) begin
      if (rst) begin
         snap      <= '0;
         prev_snap <= '0;
         deb       <= '0;
         stab_cnt  <= '0;
      end else begin
         snap <= snap_nxt;
         if (frame_end) begin
            prev_snap <= snap_nxt;
            stab_cnt  <= stab_nxt;
            if (stab_nxt == DN) deb <= snap_nxt;
         end
      end
   end
   // classify the accepted snapshot: single key and its index
   always_comb begin
      idx = '0;
      for (int i = 0; i < 16; i++)
         if (deb[i]) idx = 4'(i);
      one_hot = deb != '0 && (deb & (deb - 16'd1)) == '0;
   end
   // press tracking: a pulse only on a clean transition from all-released to one key
   always_comb begin
      state_nxt = state;
      num_nxt = num;
      vld_nxt = 1'b0;
      case (state)
         IDLE: begin
            state_nxt = one_hot ? PRESS : (deb != '0 ? MULTI : IDLE);
            num_nxt = one_hot ? idx : num;
            vld_nxt = one_hot;
         end
         PRESS: state_nxt = deb == '0 ? IDLE : (deb != (16'd1 << num) ? MULTI : PRESS);
         default: state_nxt = deb == '0 ? IDLE : MULTI;
      endcase
   end
   // FSM state and registered event outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         num   <= '0;
         vld   <= 1'b0;
      end else begin
         state <= state_nxt;
         num   <= num_nxt;
         vld   <= vld_nxt;
      end
   end
endmodule

// File: tb/tb_key_scan.sv
// tb_key_scan: frame-level keypad model with a scoreboard of expected key events
module tb_key_scan;
   localparam int SC = 4;
   localparam int DB = 3;
   localparam int FR = 4 * SC;
   typedef struct {logic [3:0] num; int cyc;} exp_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] pressed = '0;
   logic [15:0] hist[$];
   logic [15:0] acc = '0;
   logic        down_exp = 1'b0;
   logic [3:0]  num_hold = '0;
   logic [3:0]  col_exp;
   int          frame_no = 0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        sb[$];
   exp_t        e;
   key_scan_if bus();
   key_scan #(.SCAN_CYC(SC), .DEBOUNCE_N(DB)) dut (.clk(clk), .rst(rst), .bus(bus.master));
   always #5 clk = ~clk;
   // cycle index counted from the last reset edge
   always @(posedge clk) cyc <= rst ? 0 : cyc + 1;
   // physical keypad: a row reads low when a held key sits on the driven column
   always_comb begin
      for (int r = 0; r < 4; r++) bus.key_row[r] = ~|(pressed[r*4 +: 4] & ~bus.key_col);
   end
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask
   // accepted state = a key set seen unchanged for DB consecutive frames; pulse on 0 -> single key
   task automatic model_frame(input logic [15:0] keys);
      int run;
      exp_t x;
      run = 0;
      hist.push_back(keys);
      for (int i = hist.size() - 1; i >= 0 && hist[i] == keys; i--) run++;
      if (run >= DB && keys != acc) begin
         if (acc == '0 && $countones(keys) == 1) begin
            x.num = 4'($clog2(keys));
            x.cyc = FR * frame_no + FR + 1;
            sb.push_back(x);
            down_exp = 1'b1;
         end else down_exp = 1'b0;
         acc = keys;
      end
      frame_no++;
   endtask
   task automatic run_frame(input logic [15:0] keys);
      logic de;
      de = down_exp;
      model_frame(keys);
      pressed = keys;
      repeat (FR / 2) @(negedge clk);
      chk("key_down", bus.key_down, de);
      repeat (FR / 2) @(negedge clk);
   endtask
   task automatic hold(input logic [15:0] keys, input int n);
      for (int i = 0; i < n; i++) run_frame(keys);
   endtask
   task automatic chk_reset_vals();
      chk("rst_key_col", bus.key_col, 4'b1110);
      chk("rst_key_vld", bus.key_vld, 0);
      chk("rst_key_num", bus.key_num, 0);
      chk("rst_key_down", bus.key_down, 0);
   endtask
   // monitor: column scan order, event pops against the scoreboard, key_num holding
   always @(negedge clk) begin
      if (!rst) begin
         col_exp = ~(4'b0001 << ((cyc / SC) % 4));
         chk("key_col", bus.key_col, col_exp);
         if (bus.key_vld) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_vld: key_vld=1 key_num=%0d, expected no event, cycle %0d", bus.key_num, cyc);
            end else begin
               e = sb.pop_front();
               chk("vld_key_num", bus.key_num, e.num);
               chk("vld_cycle", cyc, e.cyc);
               chk("vld_key_down", bus.key_down, 1);
               num_hold = e.num;
            end
         end else chk("key_num_hold", bus.key_num, num_hold);
      end else num_hold = '0;
   end
   initial begin
      repeat (2) @(negedge clk);
      chk_reset_vals();
      rst = 1'b0;
      hold('0, 2);
      hold(16'h0040, 5);
      hold('0, 4);
      for (int i = 0; i < 6; i++) run_frame(i % 2 == 0 ? 16'h0200 : 16'h0000);
      hold(16'h0200, 4);
      hold('0, 4);
      hold(16'h8001, 4);
      hold('0, 4);
      hold(16'h8000, 4);
      hold('0, 4);
      hold(16'h0008, 4);
      hold(16'h0018, 4);
      hold(16'h0010, 4);
      hold('0, 4);
      for (int s = 0; s < 25; s++) begin
         int kind;
         logic [15:0] k;
         kind = $urandom_range(0, 3);
         k = kind == 0 ? 16'h0 : 16'h1 << $urandom_range(0, 15);
         if (kind == 3) k = k | (16'h1 << $urandom_range(0, 15));
         hold(k, $urandom_range(1, 5));
      end
      hold('0, 4);
      hold(16'h0020, 2);
      repeat ($urandom_range(1, 15)) @(negedge clk);
      chk("sb_empty_before_reset", sb.size(), 0);
      rst = 1'b1;
      @(negedge clk);
      chk_reset_vals();
      @(negedge clk);
      rst = 1'b0;
      hist.delete();
      acc = '0;
      down_exp = 1'b0;
      frame_no = 0;
      hold(16'h0020, 5);
      hold('0, 4);
      chk("sb_empty_at_end", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
